// File: rtl/leaf_pkg.sv
// Shared types and default parameters for the leaf stream accumulator.
package leaf_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } leaf_state_e;

    localparam int DATA_W_DEFAULT = 8;
    localparam int COUNT_DEFAULT  = 4;

endpackage

// File: rtl/leaf_stream_accumulator.sv
// Sums groups of COUNT samples (or shorter groups closed by in_last) and
// presents each sum with its sample count on a valid/ready output.
module leaf_stream_accumulator
    import leaf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int COUNT  = COUNT_DEFAULT,
    localparam int SUM_W = DATA_W + $clog2(COUNT),
    localparam int CNT_W = $clog2(COUNT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count
);

    leaf_state_e      state_reg, state_next;
    logic [SUM_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [SUM_W-1:0] sum_reg, sum_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [SUM_W-1:0] acc_plus;
    logic [CNT_W-1:0] cnt_plus;
    logic             closing;

    assign acc_plus = acc_reg + SUM_W'(in_data);
    assign cnt_plus = cnt_reg + CNT_W'(1);
    assign closing  = (cnt_reg == CNT_W'(COUNT - 1)) || in_last;

    // in_ready depends only on state and clear, never on out_ready.
    assign in_ready  = (state_reg == ACCUM) && !clear;
    assign out_valid = (state_reg == HOLD);
    assign out_sum   = sum_reg;
    assign out_count = count_reg;

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        sum_next   = sum_reg;
        count_next = count_reg;
        if (clear) begin
            state_next = ACCUM;
            acc_next   = '0;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (in_valid) begin
                        if (closing) begin
                            sum_next   = acc_plus;
                            count_next = cnt_plus;
                            acc_next   = '0;
                            cnt_next   = '0;
                            state_next = HOLD;
                        end else begin
                            acc_next = acc_plus;
                            cnt_next = cnt_plus;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_next = ACCUM;
                    end
                end
                default: state_next = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ACCUM;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            sum_reg   <= sum_next;
            count_reg <= count_next;
        end
    end

endmodule

// File: tb/tb_leaf_stream_accumulator.sv
// Directed, table-driven checks of leaf_stream_accumulator (DATA_W=8, COUNT=4).
module tb_leaf_stream_accumulator;

    localparam int DATA_W = 8;
    localparam int COUNT  = 4;
    localparam int SUM_W  = DATA_W + $clog2(COUNT);
    localparam int CNT_W  = $clog2(COUNT + 1);

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic              v;
        logic [DATA_W-1:0] d;
        logic              last;
        logic              ordy;
        logic              clr;
        logic              exp_ir;
        logic              exp_ov;
        logic [SUM_W-1:0]  exp_sum;
        logic [CNT_W-1:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    leaf_stream_accumulator #(
        .DATA_W(DATA_W),
        .COUNT (COUNT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_count(out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input int d, input logic last, input logic ordy,
                       input logic clr, input logic ir, input logic ov,
                       input int s, input int c);
        vec_t r;
        r.v = v; r.d = DATA_W'(d); r.last = last; r.ordy = ordy; r.clr = clr;
        r.exp_ir = ir; r.exp_ov = ov; r.exp_sum = SUM_W'(s); r.exp_cnt = CNT_W'(c);
        vecs.push_back(r);
    endtask

    // Drive one cycle of inputs at the falling edge, check outputs before the rising edge.
    task automatic step(input int idx, input vec_t r);
        @(negedge clk);
        in_valid = r.v; in_data = r.d; in_last = r.last; out_ready = r.ordy; clear = r.clr;
        #1;
        $display("vec %0d: v=%0d d=%0d last=%0d ordy=%0d clr=%0d -> ir=%0d ov=%0d sum=%0d cnt=%0d",
                 idx, r.v, r.d, r.last, r.ordy, r.clr, in_ready, out_valid, out_sum, out_count);
        chk("in_ready", 32'(in_ready), 32'(r.exp_ir));
        chk("out_valid", 32'(out_valid), 32'(r.exp_ov));
        if (r.exp_ov) begin
            chk("out_sum", 32'(out_sum), 32'(r.exp_sum));
            chk("out_count", 32'(out_count), 32'(r.exp_cnt));
        end
    endtask

    initial begin
        vec_t r;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;

        // Basic full group 1,2,3,4; one bubble cycle then in_ready returns.
        add(1, 1, 0, 1, 0, 1, 0, 0, 0);
        add(1, 2, 0, 1, 0, 1, 0, 0, 0);
        add(1, 3, 0, 1, 0, 1, 0, 0, 0);
        add(1, 4, 0, 1, 0, 1, 0, 0, 0);
        add(1, 99, 0, 1, 0, 0, 1, 10, 4);
        add(0, 0, 0, 1, 0, 1, 0, 0, 0);
        // Max values.
        for (int i = 0; i < 4; i++) add(1, 255, 0, 1, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 1, 1020, 4);
        add(0, 0, 0, 1, 0, 1, 0, 0, 0);
        // Early close with five cycles of backpressure.
        add(1, 7, 0, 0, 0, 1, 0, 0, 0);
        add(1, 9, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(1, 100, 0, 0, 0, 0, 1, 16, 2);
        add(1, 100, 0, 1, 0, 0, 1, 16, 2);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0);
        // in_last on the COUNTth sample closes a single group.
        add(1, 1, 0, 1, 0, 1, 0, 0, 0);
        add(1, 1, 0, 1, 0, 1, 0, 0, 0);
        add(1, 1, 0, 1, 0, 1, 0, 0, 0);
        add(1, 1, 1, 1, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 1, 4, 4);
        add(0, 0, 0, 1, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 1, 0, 0, 0);
        add(1, 5, 0, 1, 0, 1, 0, 0, 0);
        add(1, 5, 1, 1, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 1, 10, 2);
        add(0, 0, 0, 1, 0, 1, 0, 0, 0);
        // Clear mid-group: the sample presented with clear is refused and 3,3 is dropped.
        add(1, 3, 0, 1, 0, 1, 0, 0, 0);
        add(1, 3, 0, 1, 0, 1, 0, 0, 0);
        add(1, 50, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(1, 1, 0, 1, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 1, 4, 4);
        add(0, 0, 0, 1, 0, 1, 0, 0, 0);
        // Clear in HOLD with out_ready=1 drops the result.
        for (int i = 0; i < 3; i++) add(1, 2, 0, 0, 0, 1, 0, 0, 0);
        add(1, 2, 1, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 1, 8, 4);
        add(0, 0, 0, 1, 0, 1, 0, 0, 0);
        add(1, 6, 1, 1, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 1, 6, 1);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0);

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_sum", 32'(out_sum), 32'd0);
        chk("reset out_count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-reset in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) step(i, vecs[i]);

        // Asynchronous reset asserted while a result is held.
        r = '{v: 1, d: 9, last: 0, ordy: 0, clr: 0, exp_ir: 1, exp_ov: 0, exp_sum: 0, exp_cnt: 0};
        step(100, r);
        r.last = 1;
        step(101, r);
        r = '{v: 0, d: 0, last: 0, ordy: 0, clr: 0, exp_ir: 0, exp_ov: 1, exp_sum: 18, exp_cnt: 2};
        step(102, r);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset in HOLD: ov=%0d sum=%0d cnt=%0d", out_valid, out_sum, out_count);
        chk("async reset out_valid", 32'(out_valid), 32'd0);
        chk("async reset out_sum", 32'(out_sum), 32'd0);
        chk("async reset out_count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        r = '{v: 1, d: 2, last: 0, ordy: 1, clr: 0, exp_ir: 1, exp_ov: 0, exp_sum: 0, exp_cnt: 0};
        for (int i = 0; i < 4; i++) step(103 + i, r);
        r = '{v: 0, d: 0, last: 0, ordy: 1, clr: 0, exp_ir: 0, exp_ov: 1, exp_sum: 8, exp_cnt: 4};
        step(107, r);
        r = '{v: 0, d: 0, last: 0, ordy: 1, clr: 0, exp_ir: 1, exp_ov: 0, exp_sum: 0, exp_cnt: 0};
        step(108, r);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
